div_unit: RTL and testbench

Iterative 32-bit restoring divider. It is the subtract-direction counterpart to the team's 32-bit carry-lookahead adder and serves as the multi-cycle divide unit beside the ALU in the processor datapath. It accepts a dividend/divisor pair on a start pulse and produces quotient and remainder after a fixed number of cycles. Divide-by-zero and signed overflow take a one-cycle fast path with exception flags.

---
 rtl/div_pkg.sv | 23 ++
 rtl/div_unit_if.sv | 27 ++
 rtl/div_step.sv | 29 ++
 rtl/div_unit.sv | 192 +++++++++++++++++++
 tb/tb_div_unit.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the iterative restoring divider: widths, FSM encoding,
// the most-negative 32-bit value, and a magnitude helper for the signed build.
// Latency and backpressure behaviour: not applicable (no logic).
package div_pkg;

    localparam int WIDTH   = 32;
    localparam int COUNT_W = 5;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        FIX       = 2'd2,
        DONE_FAST = 2'd3
    } state_e;

    localparam logic [WIDTH-1:0] INT_MIN = 32'h8000_0000;

    // Two's-complement magnitude; INT_MIN maps to 0x80000000 read as unsigned.
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

endpackage

// File: rtl/div_unit_if.sv
// Request/result bundle between a requester and the divider.
// Latency: none (wiring only).
// Backpressure: none; the requester must watch busy before pulsing start.
interface div_unit_if;
    import div_pkg::*;

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output start, dividend, divisor,
        input  busy, ready, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, ready, quotient, remainder, div_by_zero, overflow
    );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left, trial-subtract divisor.
// Latency: purely combinational.
// Backpressure: none.
module div_step
    import div_pkg::*;
#(
    parameter int STEP_W = WIDTH
) (
    input  logic [STEP_W:0]   rem_i,
    input  logic [STEP_W-1:0] quo_i,
    input  logic [STEP_W-1:0] dvsr_i,
    output logic [STEP_W:0]   rem_o,
    output logic [STEP_W-1:0] quo_o
);

    logic [STEP_W+1:0] shifted;
    logic [STEP_W:0]   diff;
    logic              fits;

    // Keep the difference when the divisor fits, otherwise restore the shifted value.
    always_comb begin
        shifted = {rem_i, quo_i[STEP_W-1]};
        fits    = (shifted >= {2'b00, dvsr_i});
        diff    = shifted[STEP_W:0] - {1'b0, dvsr_i};
        rem_o   = fits ? diff : shifted[STEP_W:0];
        quo_o   = {quo_i[STEP_W-2:0], fits};
    end

endmodule

// File: rtl/div_unit.sv
// Iterative 32-bit restoring divider; DIV_SIGNED_EN selects two's-complement operands.
// Latency: 33 cycles start-to-ready, 1 cycle for divide-by-zero / signed overflow.
// Backpressure: start is ignored while busy=1; results hold until the next result edge.
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = div_pkg::WIDTH
) (
    input  logic       clock,
    input  logic       reset_n,
    div_unit_if.slave  bus
);

    state_e             state_q, state_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dvsr_q, dvsr_d;
    logic               busy_q, busy_d;
    logic               ready_q, ready_d;
    logic [WIDTH-1:0]   quotient_q, quotient_d;
    logic [WIDTH-1:0]   remainder_q, remainder_d;
    logic               dbz_q, dbz_d;
`ifdef DIV_SIGNED_EN
    logic               ovf_q, ovf_d;
    logic               exc_ovf_q, exc_ovf_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
`endif

    logic [WIDTH:0]     rem_nxt;
    logic [WIDTH-1:0]   quo_nxt;

    div_step #(.STEP_W(WIDTH)) u_step (
        .rem_i  (rem_q),
        .quo_i  (quo_q),
        .dvsr_i (dvsr_q),
        .rem_o  (rem_nxt),
        .quo_o  (quo_nxt)
    );

    // Next-state logic: operand load, iteration, sign fix-up and exception results.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvsr_d      = dvsr_q;
        busy_d      = busy_q;
        ready_d     = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
`ifdef DIV_SIGNED_EN
        ovf_d       = ovf_q;
        exc_ovf_d   = exc_ovf_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    busy_d  = 1'b1;
                    dbz_d   = 1'b0;
                    rem_d   = '0;
                    count_d = COUNT_W'(WIDTH - 1);
`ifdef DIV_SIGNED_EN
                    ovf_d     = 1'b0;
                    exc_ovf_d = 1'b0;
                    neg_quo_d = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                    neg_rem_d = bus.dividend[WIDTH-1];
                    dvsr_d    = abs_val(bus.divisor);
`else
                    dvsr_d    = bus.divisor;
`endif
                    if (bus.divisor == '0) begin
                        // Raw dividend is parked here so the fast path can return it.
                        quo_d   = bus.dividend;
                        state_d = DONE_FAST;
                    end
`ifdef DIV_SIGNED_EN
                    else if (bus.dividend == INT_MIN && bus.divisor == '1) begin
                        exc_ovf_d = 1'b1;
                        state_d   = DONE_FAST;
                    end
`endif
                    else begin
`ifdef DIV_SIGNED_EN
                        quo_d = abs_val(bus.dividend);
`else
                        quo_d = bus.dividend;
`endif
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                rem_d = rem_nxt;
                quo_d = quo_nxt;
                if (count_q == '0) begin
                    state_d = FIX;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
            FIX: begin
`ifdef DIV_SIGNED_EN
                quotient_d  = neg_quo_q ? -quo_q : quo_q;
                remainder_d = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
`else
                quotient_d  = quo_q;
                remainder_d = rem_q[WIDTH-1:0];
`endif
                ready_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            DONE_FAST: begin
`ifdef DIV_SIGNED_EN
                if (exc_ovf_q) begin
                    quotient_d  = INT_MIN;
                    remainder_d = '0;
                    ovf_d       = 1'b1;
                end else begin
                    quotient_d  = '0;
                    remainder_d = quo_q;
                    dbz_d       = 1'b1;
                end
`else
                quotient_d  = '0;
                remainder_d = quo_q;
                dbz_d       = 1'b1;
`endif
                ready_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
`ifdef DIV_SIGNED_EN
            ovf_q       <= 1'b0;
            exc_ovf_q   <= 1'b0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvsr_q      <= dvsr_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
`ifdef DIV_SIGNED_EN
            ovf_q       <= ovf_d;
            exc_ovf_q   <= exc_ovf_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
`endif
        end
    end

    assign bus.busy        = busy_q;
    assign bus.ready       = ready_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;
`ifdef DIV_SIGNED_EN
    assign bus.overflow    = ovf_q;
`else
    assign bus.overflow    = 1'b0;
`endif

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: fixed vector table, corner sequences, random ops vs an arithmetic model.
// Latency: checks 33-cycle normal and 1-cycle exception results.
// Backpressure: checks that start during busy is ignored.
module tb_div_unit;

    localparam int MAX_WAIT = 60;

    logic clock;
    logic reset_n;

    div_unit_if bus ();

    div_unit dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        ov;
        int          lat;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] a, b, q, r, input logic dz, ov, input int lat);
        vec_t v;
        v.a = a; v.b = b; v.q = q; v.r = r; v.dz = dz; v.ov = ov; v.lat = lat;
        return v;
    endfunction

    // Arithmetic reference: language division operators plus the exception rules.
    function automatic vec_t ref_model(input logic [31:0] a, b);
        vec_t v;
        v.a = a; v.b = b; v.dz = 1'b0; v.ov = 1'b0; v.lat = 33;
        if (b == 32'd0) begin
            v.q = 32'd0; v.r = a; v.dz = 1'b1; v.lat = 1;
        end else begin
`ifdef DIV_SIGNED_EN
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                v.q = 32'h8000_0000; v.r = 32'd0; v.ov = 1'b1; v.lat = 1;
            end else begin
                int sa;
                int sb;
                sa = a;
                sb = b;
                v.q = sa / sb;
                v.r = sa % sb;
            end
`else
            v.q = a / b;
            v.r = a % b;
`endif
        end
        return v;
    endfunction

    // Issue one op from the current point (just after an edge); return at the ready sample.
    task automatic do_op(input logic [31:0] a, b, input int inj_cyc,
                         output logic [31:0] q, r, output logic dz, ov,
                         output int lat, output int bad_busy);
        bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
        @(posedge clock); #1;
        bus.start = 1'b0; bus.dividend = $urandom; bus.divisor = $urandom;
        bad_busy = bus.busy ? 0 : 1;
        lat = -1; q = '0; r = '0; dz = 1'b0; ov = 1'b0;
        for (int n = 1; n <= MAX_WAIT; n++) begin
            if (n == inj_cyc) begin
                bus.start = 1'b1; bus.dividend = 32'd50; bus.divisor = 32'd5;
            end
            @(posedge clock); #1;
            bus.start = 1'b0;
            if (bus.ready) begin
                lat = n;
                q = bus.quotient; r = bus.remainder;
                dz = bus.div_by_zero; ov = bus.overflow;
                if (bus.busy) bad_busy++;
                break;
            end else if (!bus.busy) begin
                bad_busy++;
            end
        end
    endtask

    task automatic check_op(input string tag, input vec_t e, input int inj_cyc, input bit pulse_chk);
        logic [31:0] q, r;
        logic dz, ov;
        int lat, bad_busy;
        do_op(e.a, e.b, inj_cyc, q, r, dz, ov, lat, bad_busy);
        check({tag, " quotient"}, q, e.q);
        check({tag, " remainder"}, r, e.r);
        check({tag, " div_by_zero"}, 32'(dz), 32'(e.dz));
        check({tag, " overflow"}, 32'(ov), 32'(e.ov));
        check({tag, " latency"}, 32'(lat), 32'(e.lat));
        check({tag, " busy window"}, 32'(bad_busy), 32'd0);
        if (pulse_chk) begin
            @(posedge clock); #1;
            check({tag, " ready single pulse"}, 32'(bus.ready), 32'd0);
        end
    endtask

    initial begin
        vec_t vecs[$];
        int ready_cnt;

        // Spec vectors first; sign-dependent entries differ between builds.
        vecs.push_back(mk(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 33));
        vecs.push_back(mk(32'd5, 32'd0, 32'd0, 32'd5, 1'b1, 1'b0, 1));
        vecs.push_back(mk(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0, 33));
        vecs.push_back(mk(32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0, 33));
        vecs.push_back(mk(32'd100, 32'd100, 32'd1, 32'd0, 1'b0, 1'b0, 33));
        vecs.push_back(mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 33));
        vecs.push_back(mk(32'hDEAD_BEEF, 32'd1, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0, 33));
        vecs.push_back(mk(32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0, 1'b0, 33));
        vecs.push_back(mk(32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1));
`ifdef DIV_SIGNED_EN
        vecs.push_back(mk(32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0, 33));
        vecs.push_back(mk(32'hFFFF_FFFF, 32'd2, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 33));
        vecs.push_back(mk(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b1, 1));
        vecs.push_back(mk(32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0, 33));
`else
        vecs.push_back(mk(32'hFFFF_FF9C, 32'd7, 32'h2492_4916, 32'd2, 1'b0, 1'b0, 33));
        vecs.push_back(mk(32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 33));
        vecs.push_back(mk(32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 1'b0, 33));
        vecs.push_back(mk(32'd7, 32'hFFFF_FFFE, 32'd0, 32'd7, 1'b0, 1'b0, 33));
`endif

        bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset ready", 32'(bus.ready), 32'd0);
        check("reset quotient", bus.quotient, 32'd0);
        check("reset remainder", bus.remainder, 32'd0);
        check("reset div_by_zero", 32'(bus.div_by_zero), 32'd0);
        check("reset overflow", 32'(bus.overflow), 32'd0);

        foreach (vecs[i]) check_op($sformatf("vec%0d", i), vecs[i], 0, 1'b1);

        // Start pulsed mid-operation must not disturb the in-flight divide.
        check_op("ignored start", mk(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 33), 10, 1'b1);

        // Divide-by-zero followed directly by a normal op clears the flag.
        check_op("dbz first", mk(32'd5, 32'd0, 32'd0, 32'd5, 1'b1, 1'b0, 1), 0, 1'b0);
        check_op("after dbz", mk(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0, 33), 0, 1'b0);
        // Start raised in the ready cycle is accepted: 34 cycles per result.
        check_op("back-to-back", mk(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 33), 0, 1'b1);

        // Reset in the middle of an operation discards it silently.
        bus.start = 1'b1; bus.dividend = 32'd100; bus.divisor = 32'd7;
        @(posedge clock); #1;
        bus.start = 1'b0;
        repeat (14) begin @(posedge clock); #1; end
        reset_n = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        check("midreset busy", 32'(bus.busy), 32'd0);
        check("midreset ready", 32'(bus.ready), 32'd0);
        check("midreset quotient", bus.quotient, 32'd0);
        check("midreset remainder", bus.remainder, 32'd0);
        check("midreset div_by_zero", 32'(bus.div_by_zero), 32'd0);
        ready_cnt = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (bus.ready || bus.busy) ready_cnt++;
        end
        check("midreset no ready/busy", 32'(ready_cnt), 32'd0);
        check_op("after reset", mk(32'd8, 32'd2, 32'd4, 32'd0, 1'b0, 1'b0, 33), 0, 1'b1);

        // Random operands with a mix of divisor classes.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = 32'hFFFF_FFFF;
                3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                4: b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            check_op($sformatf("rand%0d", i), ref_model(a, b), 0, (i % 2) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
